mem_readback_unit: RTL and testbench

- Debug readback engine for the CPU's 2048-word memory, paired with the existing host write/load path (w_instruction/w_enable/w_adrs).
- While the CPU is halted (cpu_en=0), it sequentially reads an inclusive address range from the memory's read port.
- It presents each word, tagged with its address, to a host over a valid/ready handshake. Used by benches and the debug host to dump memory after a program run.

---
 rtl/mem_readback_unit_if.sv | 33 +++
 rtl/mem_readback_unit.sv | 136 +++++++++++++
 tb/tb_mem_readback_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_readback_unit_if.sv
// ---------------------------------------------------------------------------
// mem_readback_unit_if
// Bus bundle for the memory readback engine.
//   Memory read port : r_enable, r_adrs (engine -> memory), r_data (memory -> engine)
//   Host stream      : rd_data, rd_adrs, rd_valid (engine -> host), rd_ready (host -> engine)
// master = readback engine side, slave = memory + host side.
// ---------------------------------------------------------------------------
interface mem_readback_unit_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  r_enable;
  logic [ADDR_WIDTH-1:0] r_adrs;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_adrs;
  logic                  rd_valid;
  logic                  rd_ready;

  modport master (
    output r_enable, r_adrs,
    input  r_data,
    output rd_data, rd_adrs, rd_valid,
    input  rd_ready
  );

  modport slave (
    input  r_enable, r_adrs,
    output r_data,
    input  rd_data, rd_adrs, rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/mem_readback_unit.sv
// ---------------------------------------------------------------------------
// mem_readback_unit
// Debug readback engine: while the CPU is halted, reads an inclusive address
// range from the memory read port one word at a time and hands each word,
// tagged with its address, to a host over a valid/ready handshake.
//
// Ports
//   clk, resetn          : clock (rising edge), synchronous active-low reset
//   cpu_en               : CPU run enable; dumps only run while this is 0
//   start                : dump request, sampled in IDLE only
//   start_adrs, end_adrs : inclusive range to dump
//   rb (master)          : memory read port + host word stream
//   busy                 : dump in progress (ISSUE..HOLD of last word)
//   done                 : one-cycle pulse after the last word is accepted
//   err                  : sticky; set on rejected start or abort
// ---------------------------------------------------------------------------
module mem_readback_unit #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_en,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_adrs,
  input  logic [ADDR_WIDTH-1:0] end_adrs,
  mem_readback_unit_if.master   rb,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_FINISH
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cur_q, last_q;
  logic [CW-1:0]         cnt_q;
  logic                  r_enable_q, rd_valid_q, busy_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] r_adrs_q, rd_adrs_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Outputs are driven straight from registers; each is set on entry to the
  // state that owns it so it is visible for that state's whole cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      r_enable_q <= 1'b0;
      r_adrs_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_adrs_q  <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (state_q != S_IDLE && cpu_en) begin
      // CPU restarted under us: abandon the dump, no done pulse.
      state_q    <= S_IDLE;
      r_enable_q <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!cpu_en && (start_adrs <= end_adrs)) begin
              cur_q      <= start_adrs;
              last_q     <= end_adrs;
              err_q      <= 1'b0;
              r_enable_q <= 1'b1;
              r_adrs_q   <= start_adrs;
              busy_q     <= 1'b1;
              state_q    <= S_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_enable_q <= 1'b0;
          cnt_q      <= CW'(RD_LATENCY - 1);
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // Stay RD_LATENCY cycles so r_data is the word for cur_q.
          if (cnt_q == '0) begin
            rd_data_q  <= rb.r_data;
            rd_adrs_q  <= cur_q;
            rd_valid_q <= 1'b1;
            state_q    <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (rb.rd_ready) begin
            rd_valid_q <= 1'b0;
            // Compare before incrementing so end_adrs = max never wraps.
            if (cur_q == last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              cur_q      <= cur_q + 1'b1;
              r_adrs_q   <= cur_q + 1'b1;
              r_enable_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign rb.r_enable = r_enable_q;
  assign rb.r_adrs   = r_adrs_q;
  assign rb.rd_valid = rd_valid_q;
  assign rb.rd_adrs  = rd_adrs_q;
  assign rb.rd_data  = rd_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_readback_unit.sv
module tb_mem_readback_unit;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cpu_en = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_adrs = '0;
  logic [AW-1:0] end_adrs = '0;
  logic          busy, done, err;

  mem_readback_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_readback_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .start(start),
    .start_adrs(start_adrs), .end_adrs(end_adrs), .rb(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears LAT edges after the strobe, garbage otherwise.
  logic [DW-1:0] mem [2048];
  logic [DW-1:0] dpipe [LAT];
  bit            vpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= mem[bus.r_adrs];
    vpipe[0] <= bus.r_enable;
    for (int i = 1; i < LAT; i++) begin
      dpipe[i] <= dpipe[i-1];
      vpipe[i] <= vpipe[i-1];
    end
  end
  assign bus.r_data = vpipe[LAT-1] ? dpipe[LAT-1] : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  int   checks = 0, fails = 0;
  int   hs_cnt = 0, ren_cnt = 0, done_cnt = 0, zero_cnt = 0;
  bit   m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold stability.
  bit            prev_v = 0, prev_r = 0;
  logic [DW-1:0] prev_d;
  logic [AW-1:0] prev_a;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_v = 0;
    end else begin
      if (bus.r_enable) begin
        ren_cnt++;
        if (bus.r_adrs == '0) zero_cnt++;
        chk("ren_while_cpu_en", cpu_en, 0);
      end
      if (done) done_cnt++;
      if (prev_v && !prev_r && bus.rd_valid) begin
        chk("hold_data", bus.rd_data, prev_d);
        chk("hold_adrs", bus.rd_adrs, prev_a);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_adrs", bus.rd_adrs, e.a);
          chk("word_data", bus.rd_data, e.d);
        end
      end
      prev_v = bus.rd_valid;
      prev_r = bus.rd_ready;
      prev_d = bus.rd_data;
      prev_a = bus.rd_adrs;
    end
  end

  // Present a start for one cycle; the reference model expands the range.
  task automatic issue(input int s, input int e);
    start = 1'b1;
    start_adrs = AW'(s);
    end_adrs = AW'(e);
    if (!cpu_en && s <= e) begin
      m_err = 0;
      for (int a = s; a <= e; a++) exp_q.push_back('{a: AW'(a), d: mem[a]});
    end else begin
      m_err = 1;
    end
    tick();
    start = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on address 5
  task automatic run_dump(input int s, input int e, input int mode);
    int  hs0, ren0, dn0, stall;
    bit  got;
    hs0 = hs_cnt; ren0 = ren_cnt; dn0 = done_cnt; stall = 0; got = 0;
    bus.rd_ready = 1'b1;
    issue(s, e);
    for (int c = 0; c < 400 && !got; c++) begin
      if (done) begin
        got = 1;
        chk("busy_at_done", busy, 0);
      end else begin
        case (mode)
          1: bus.rd_ready = ($urandom_range(0, 2) != 0);
          2: if (bus.rd_valid && bus.rd_adrs == 5 && stall < 3) begin
               bus.rd_ready = 1'b0;
               stall++;
             end else bus.rd_ready = 1'b1;
          default: bus.rd_ready = 1'b1;
        endcase
        tick();
      end
    end
    chk("done_seen", got, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("handshakes", hs_cnt - hs0, e - s + 1);
    chk("r_enables", ren_cnt - ren0, e - s + 1);
    chk("done_pulses", done_cnt - dn0, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("err_after_dump", err, m_err);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_r_enable", bus.r_enable, 0);
    chk("rst_r_adrs", bus.r_adrs, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_adrs", bus.rd_adrs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ren0, dn0, z0, hs0, s, e;
    bit seen;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    bus.rd_ready = 1'b1;
    tick(); tick();
    chk_reset_outputs();
    resetn = 1'b1;
    tick();

    // 1: single word, cycle-exact
    mem[7] = 32'h1234_5678;
    hs0 = hs_cnt; dn0 = done_cnt;
    issue(7, 7);
    chk("t1_c1_r_enable", bus.r_enable, 1);
    chk("t1_c1_r_adrs", bus.r_adrs, 7);
    chk("t1_c1_busy", busy, 1);
    tick();
    chk("t1_c2_r_enable", bus.r_enable, 0);
    chk("t1_c2_rd_valid", bus.rd_valid, 0);
    tick();
    chk("t1_c3_rd_valid", bus.rd_valid, 1);
    chk("t1_c3_rd_data", bus.rd_data, 32'h1234_5678);
    chk("t1_c3_rd_adrs", bus.rd_adrs, 7);
    tick();
    chk("t1_c4_done", done, 1);
    chk("t1_c4_busy", busy, 0);
    chk("t1_c4_rd_valid", bus.rd_valid, 0);
    tick();
    chk("t1_c5_done", done, 0);
    chk("t1_err", err, 0);
    chk("t1_handshakes", hs_cnt - hs0, 1);
    chk("t1_done_pulses", done_cnt - dn0, 1);

    // 2: range with backpressure on word 5
    for (int i = 0; i < 4; i++) mem[4+i] = 32'hA0 + i;
    run_dump(4, 7, 2);

    // 3: top of memory
    z0 = zero_cnt;
    run_dump(2045, 2047, 0);
    chk("t3_no_adrs_zero", zero_cnt - z0, 0);
    chk("t3_busy_low", busy, 0);

    // 4: rejected requests
    ren0 = ren_cnt; dn0 = done_cnt;
    issue(10, 3);
    chk("t4_err_range", err, m_err);
    chk("t4_no_ren", bus.r_enable, 0);
    tick(); tick();
    cpu_en = 1'b1;
    issue(0, 0);
    cpu_en = 1'b0;
    tick(); tick();
    chk("t4_err_cpu", err, m_err);
    chk("t4_busy", busy, 0);
    chk("t4_ren_count", ren_cnt - ren0, 0);
    chk("t4_done_count", done_cnt - dn0, 0);
    run_dump(0, 0, 0);

    // 5: abort after the second handshake
    hs0 = hs_cnt; dn0 = done_cnt;
    bus.rd_ready = 1'b1;
    issue(0, 15);
    for (int c = 0; c < 50 && (hs_cnt - hs0) < 2; c++) tick();
    bus.rd_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.rd_valid) seen = 1; else tick();
    end
    chk("t5_third_word_valid", seen, 1);
    cpu_en = 1'b1;
    m_err = 1;
    ren0 = ren_cnt;
    tick();
    chk("t5_rd_valid", bus.rd_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err, m_err);
    chk("t5_r_enable", bus.r_enable, 0);
    for (int i = 0; i < 4; i++) tick();
    cpu_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_no_more_ren", ren_cnt - ren0, 0);
    chk("t5_no_done", done_cnt - dn0, 0);
    chk("t5_handshakes", hs_cnt - hs0, 2);
    chk("t5_words_left", exp_q.size(), 14);
    exp_q.delete();

    // 6: reset while a word is held
    bus.rd_ready = 1'b0;
    issue(0, 3);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.rd_valid) seen = 1; else tick();
    end
    chk("t6_valid_before_reset", seen, 1);
    resetn = 1'b0;
    tick();
    chk_reset_outputs();
    resetn = 1'b1;
    exp_q.delete();
    m_err = 0;
    tick();
    run_dump(7, 7, 0);

    // Randomized ranges with random host backpressure
    for (int k = 0; k < 8; k++) begin
      s = $urandom_range(0, 2047);
      e = s + $urandom_range(0, 5);
      if (e > 2047) e = 2047;
      run_dump(s, e, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
